// File: rtl/serial_encoder_if.sv
// Handshake bundle for serial_encoder: request-vector input side and code output side.
// Carries out_last only when ENC_LAST_EN is defined.
interface serial_encoder_if #(
    parameter int W  = 8,
    parameter int CW = 3
);
    logic [W-1:0]  in_vec;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] out_code;
    logic          out_valid;
    logic          out_ready;
    logic          err_zero;
`ifdef ENC_LAST_EN
    logic          out_last;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_code, out_valid, err_zero, out_last
    );
    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_code, out_valid, err_zero, out_last
    );
`else
    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_code, out_valid, err_zero
    );
    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_code, out_valid, err_zero
    );
`endif
endinterface

// File: rtl/serial_encoder.sv
// Sequential W-to-log2(W) encoder: emits the index of every set request bit, lowest first.
// Define ENC_LAST_EN to add out_last, flagging the final code of each vector.
//
// state | meaning
// IDLE  | waiting for a request vector, in_ready high
// BUSY  | draining pend, one code per accepted output beat
module serial_encoder #(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_encoder_if.slave bus
);
    generate
        if (CW != $clog2(W) || W < 2 || (W & (W - 1)) != 0) begin : g_bad_param
            $error("serial_encoder: W must be a power of two >= 2 and CW must equal $clog2(W)");
        end
    endgenerate

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [W-1:0]  pend;
    logic          err_zero;
    logic [CW-1:0] low_code;
    logic [W-1:0]  low_onehot;
    logic [W-1:0]  pend_next;
    logic          accept;
    logic          beat;

    always_comb begin
        low_code = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (pend[i]) low_code = CW'(i);
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign low_onehot = pend & (~pend + W'(1));
    assign pend_next  = pend & ~low_onehot;

    assign accept = bus.in_valid && bus.in_ready;
    assign beat   = (state == BUSY) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            err_zero <= 1'b0;
        end else begin
            err_zero <= accept && (bus.in_vec == '0);
            case (state)
                IDLE: begin
                    if (accept && bus.in_vec != '0) begin
                        pend  <= bus.in_vec;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        pend <= pend_next;
                        if (pend_next == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == BUSY);
    assign bus.out_code  = (state == BUSY) ? low_code : '0;
    assign bus.err_zero  = err_zero;

`ifdef ENC_LAST_EN
    assign bus.out_last = (state == BUSY) && (pend != '0) && ((pend & (pend - W'(1))) == '0);
`endif
endmodule
